priority_scan_encoder: RTL

//  Parametrised sequential successor to the combinational 8-3 encoder.
//  - Captures a WIDTH-bit one-hot or multi-hot request vector through a valid/ready handshake.
//  - Emits the binary index of every set bit, one index per beat, highest bit first.
//  - Each output beat has its own valid/ready handshake.
//  - Sits between request sources (switches, IRQ lines) and a consumer that handles one index at a time.

---
 rtl/priority_scan_encoder.sv | 96 +++++++++
 1 files changed

// File: rtl/priority_scan_encoder.sv
// Sequential priority encoder: captures a request vector, then emits the index of each set bit, MSB first.
// Optional end-of-vector flag oLast is enabled by defining ENC_LAST_EN.
module priority_scan_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] iData,
  input  logic             iValid,
  output logic             oReady,
  output logic [IDX_W-1:0] oData,
  output logic             oValid,
  input  logic             iReady,
  output logic             oNone
`ifdef ENC_LAST_EN
  ,
  output logic             oLast
`endif
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] remaining;

  function automatic logic [IDX_W-1:0] msb_index(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // True for zero or one-hot vectors; a zero vector's single beat is also its last.
  function automatic logic at_most_one(input logic [WIDTH-1:0] v);
    return (v & (v - ONE)) == '0;
  endfunction

  always_comb begin
    remaining = pend & ~(ONE << oData);
  end

  assign oValid = (state == SCAN);
  assign oReady = (state == IDLE) && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
      oData <= '0;
      oNone <= 1'b0;
`ifdef ENC_LAST_EN
      oLast <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (iValid) begin
            pend  <= iData;
            oData <= msb_index(iData);
            oNone <= (iData == '0);
`ifdef ENC_LAST_EN
            oLast <= at_most_one(iData);
`endif
            state <= SCAN;
          end
        end
        SCAN: begin
          if (iReady) begin
            pend <= remaining;
            if (oNone || remaining == '0) begin
              state <= IDLE;
              oData <= '0;
              oNone <= 1'b0;
`ifdef ENC_LAST_EN
              oLast <= 1'b0;
`endif
            end else begin
              oData <= msb_index(remaining);
`ifdef ENC_LAST_EN
              oLast <= at_most_one(remaining);
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
